// File: rtl/cpu_memory.sv
// rtl/cpu_memory.sv - memory-side responder for the CPU bus with load phase, IO register and cycle timer
//
// Ports:
//   clock, reset       system clock, asynchronous active-high reset
//   address, cpu_wdata CPU bus address and write data
//   rw                 1 = read, 0 = write
//   data               read data, registered on the falling edge
//   cpu_hold           high during LOAD, holds the CPU in reset
//   load_valid/_data/_last/_ready  streaming RAM load port
//   io_out, io_strobe  memory-mapped output register and its write pulse
module cpu_memory #(
  parameter int unsigned ADDR_BITS  = 10,
  parameter logic [31:0] IO_ADDR    = 32'hFFFF_FFF0,
  parameter logic [31:0] TIMER_ADDR = 32'hFFFF_FFF4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] cpu_wdata,
  input  logic        rw,
  output logic [31:0] data,
  output logic        cpu_hold,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic [31:0] io_out,
  output logic        io_strobe
);

  typedef enum logic {ST_LOAD, ST_SERVE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  load_ptr_q, load_ptr_d;
  logic [31:0]           data_q, data_d;
  logic [31:0]           io_out_q, io_out_d;
  logic                  io_strobe_q, io_strobe_d;
  logic [31:0]           timer_q, timer_d;

  logic                  mem_we;
  logic [ADDR_BITS-1:0]  mem_waddr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem [2**ADDR_BITS];

  logic                  in_ram;
  logic                  serving;

  assign in_ram  = (address[31:ADDR_BITS] == '0);
  assign serving = (state_q == ST_SERVE);

  // Rising-edge side: load stream, CPU writes, IO register, timer.
  always_comb begin
    state_d     = state_q;
    load_ptr_d  = load_ptr_q;
    io_out_d    = io_out_q;
    io_strobe_d = 1'b0;
    timer_d     = timer_q;
    mem_we      = 1'b0;
    mem_waddr   = load_ptr_q;
    mem_wdata   = load_data;
    case (state_q)
      ST_LOAD: begin
        if (load_valid) begin
          mem_we     = 1'b1;
          load_ptr_d = load_ptr_q + ADDR_BITS'(1);
          // Filling the last RAM word ends the load even without load_last.
          if (load_last || (load_ptr_q == '1)) begin
            state_d = ST_SERVE;
          end
        end
      end
      ST_SERVE: begin
        timer_d = timer_q + 32'd1;
        if (!rw) begin
          if (in_ram) begin
            mem_we    = 1'b1;
            mem_waddr = address[ADDR_BITS-1:0];
            mem_wdata = cpu_wdata;
          end else if (address == IO_ADDR) begin
            io_out_d    = cpu_wdata;
            io_strobe_d = 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
    // A write coinciding with reset must not land in RAM.
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  // Falling-edge read decode; RAM writes from the previous rising edge are
  // already visible here, giving write-then-read ordering.
  always_comb begin
    data_d = '0;
    if (serving && rw) begin
      if (in_ram) begin
        data_d = mem[address[ADDR_BITS-1:0]];
      end else if (address == IO_ADDR) begin
        data_d = io_out_q;
      end else if (address == TIMER_ADDR) begin
        data_d = timer_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      load_ptr_q  <= '0;
      io_out_q    <= '0;
      io_strobe_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      load_ptr_q  <= load_ptr_d;
      io_out_q    <= io_out_d;
      io_strobe_q <= io_strobe_d;
      timer_q     <= timer_d;
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign data       = data_q;
  assign io_out     = io_out_q;
  assign io_strobe  = io_strobe_q;
  assign cpu_hold   = (state_q == ST_LOAD);
  assign load_ready = (state_q == ST_LOAD);

endmodule
